// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
//   Frame-capture sequencer between a parallel camera (vsync/href/din) and a
//   word-addressed frame buffer. Camera pins are double-synchronised, a frame
//   start (vsync falling) is awaited, and 6-bit pixels are packed four per
//   32-bit word (byte lanes 0..3, upper two bits of each lane zero). Words are
//   written through a mem_we/mem_ack handshake.
//
//   Optional build macro: CAM_CAPTURE_DECIM_EN
//     defined   -> 2:1 horizontal decimation (even pixels of each line only)
//     undefined -> every valid pixel is packed
//
//   Ports
//     clk, rst           system clock, asynchronous active-high reset
//     start, abort       one-cycle control strobes (abort has priority)
//     vsync, href, din   asynchronous camera inputs
//     mem_we/addr/wdata  pending write, held stable until mem_ack
//     mem_ack            write accepted this cycle
//     busy, done         ARMED/CAPTURE/DRAIN, frame complete
//     overrun            sticky: a completed word was dropped
//     word_cnt           words accepted this frame (saturates at FRAME_WORDS)
module cam_capture_ctrl #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned FRAME_WORDS = 4800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              vsync,
  input  logic              href,
  input  logic [5:0]        din,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W:0] LP_FRAME_WORDS = (ADDR_W+1)'(FRAME_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // input synchronisers
  logic [1:0] r_vs_sync;
  logic [1:0] r_hr_sync;
  logic [5:0] r_d_meta;
  logic [5:0] r_d_s;
  logic       r_vs_prev;

  // packing datapath
  logic [1:0]  r_lane;
  logic [23:0] r_pack;

  logic          w_vs_s;
  logic          w_hr_s;
  logic          w_vs_fall;
  logic          w_vs_rise;
  logic          w_capture;
  logic          w_limit;
  logic          w_pix_take;
  logic          w_pix_valid;
  logic          w_word_done;
  logic          w_ack;
  logic          w_issue;
  logic          w_drop;
  logic          w_start_ok;
  logic          w_cnt_inc;
  logic [ADDR_W:0] w_cnt_next;
  logic [31:0]   w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_sync <= '0;
      r_hr_sync <= '0;
      r_d_meta  <= '0;
      r_d_s     <= '0;
      r_vs_prev <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[0], vsync};
      r_hr_sync <= {r_hr_sync[0], href};
      r_d_meta  <= din;
      r_d_s     <= r_d_meta;
      r_vs_prev <= r_vs_sync[1];
    end
  end

  assign w_vs_s    = r_vs_sync[1];
  assign w_hr_s    = r_hr_sync[1];
  assign w_vs_fall = r_vs_prev & ~w_vs_s;
  assign w_vs_rise = ~r_vs_prev & w_vs_s;

`ifdef CAM_CAPTURE_DECIM_EN
  // Phase 0 = even pixel of the current line; cleared whenever href is low.
  logic r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= 1'b0;
    end else if (!w_hr_s) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  assign w_pix_take = w_hr_s & ~r_phase;
`else
  assign w_pix_take = w_hr_s;
`endif

  assign w_capture  = (r_state == S_CAPTURE);
  // Stored plus in-flight words; once the frame quota is covered, pixels stop.
  assign w_limit    = (word_cnt + {{ADDR_W{1'b0}}, mem_we}) >= LP_FRAME_WORDS;
  assign w_pix_valid = w_capture & ~w_limit & w_pix_take;
  assign w_word_done = w_pix_valid & (r_lane == 2'd3);
  assign w_ack       = mem_we & mem_ack;
  // An ack in the same cycle frees the slot, so the new word can still issue.
  assign w_issue     = w_word_done & (~mem_we | mem_ack);
  assign w_drop      = w_word_done & mem_we & ~mem_ack;
  assign w_start_ok  = start & ~abort & ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_inc   = w_ack & (word_cnt < LP_FRAME_WORDS);
  assign w_cnt_next  = word_cnt + {{ADDR_W{1'b0}}, w_cnt_inc};
  // Lane 3 is taken straight from the synchroniser so the word issues this edge.
  assign w_word      = {2'b00, r_d_s, r_pack};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)                 w_state_nxt = S_ARMED;
      S_ARMED:   if (w_vs_fall)             w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_vs_rise || w_limit)  w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!mem_we)               w_state_nxt = S_DONE;
      S_DONE:    if (start)                 w_state_nxt = S_ARMED;
      default:                              w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // state-decoded outputs
  always_comb begin
    busy = (r_state == S_ARMED) || (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  // write port, counters and packing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overrun   <= 1'b0;
      word_cnt  <= '0;
      r_lane    <= '0;
      r_pack    <= '0;
    end else if (abort) begin
      // pending write is abandoned and not counted
      mem_we  <= 1'b0;
      overrun <= 1'b0;
      r_lane  <= '0;
    end else begin
      if (w_start_ok) begin
        word_cnt <= '0;
        overrun  <= 1'b0;
        mem_addr <= '0;
      end else begin
        word_cnt <= w_cnt_next;
        if (w_drop) begin
          overrun <= 1'b1;
        end
      end

      if (w_issue) begin
        mem_we    <= 1'b1;
        mem_addr  <= w_cnt_next[ADDR_W-1:0];
        mem_wdata <= w_word;
      end else if (w_ack) begin
        mem_we <= 1'b0;
      end

      // Outside CAPTURE the lane is held at 0, discarding any partial word.
      if (!w_capture) begin
        r_lane <= '0;
      end else if (w_pix_valid) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_pack[7:0]   <= {2'b00, r_d_s};
          2'd1:    r_pack[15:8]  <= {2'b00, r_d_s};
          2'd2:    r_pack[23:16] <= {2'b00, r_d_s};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl
//   Scoreboarded bench for cam_capture_ctrl (ADDR_W=3, FRAME_WORDS=4).
//   Expected writes are queued when a frame is planned; a monitor pops and
//   compares on each accepted write. A responder acknowledges writes with a
//   short random delay unless holding is requested.
module tb_cam_capture_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned FW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          vsync;
  logic          href;
  logic [5:0]    din;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [AW:0]   word_cnt;

  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned n_accepts = 0;
  bit          ack_auto  = 1'b1;
  int unsigned ack_wait  = 0;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .ADDR_W      (AW),
    .FRAME_WORDS (FW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .vsync     (vsync),
    .href      (href),
    .din       (din),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_frame();
    vsync = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    href = 1'b0;
    tick(3);
    vsync = 1'b1;
    tick();
  endtask

  task automatic drive_seq(input int unsigned first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      href = 1'b1;
      din  = 6'(first + i);
      tick();
    end
    href = 1'b0;
    din  = '0;
  endtask

  task automatic wait_done(input string name);
    int unsigned t;
    t = 0;
    while (!done && t < 300) begin
      tick();
      t++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_we(input string name);
    int unsigned t;
    t = 0;
    while (!mem_we && t < 50) begin
      tick();
      t++;
    end
    check({name, "_we"}, 32'(mem_we), 32'd1);
  endtask

  function automatic logic [31:0] pack4(input logic [5:0] p0, input logic [5:0] p1,
                                        input logic [5:0] p2, input logic [5:0] p3);
    return {2'b00, p3, 2'b00, p2, 2'b00, p1, 2'b00, p0};
  endfunction

  task automatic push_exp(input int unsigned addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Reference: the frame is a list of lines; the kept pixel stream is cut into
  // groups of four, at most FW of them, leftovers are lost.
  task automatic random_frame();
    logic [5:0]  pix[$];
    logic [5:0]  kept[$];
    int unsigned lens[$];
    int unsigned nlines;
    int unsigned len;
    int unsigned nexp;
    int unsigned k;
    logic [5:0]  p;
    nlines = $urandom_range(1, 3);
    for (int unsigned l = 0; l < nlines; l++) begin
      len = $urandom_range(0, 10);
      lens.push_back(len);
      for (int unsigned i = 0; i < len; i++) begin
        p = 6'($urandom);
        pix.push_back(p);
`ifdef CAM_CAPTURE_DECIM_EN
        if (i % 2 == 0) kept.push_back(p);
`else
        kept.push_back(p);
`endif
      end
    end
    nexp = kept.size() / 4;
    if (nexp > FW) nexp = FW;
    for (int unsigned w = 0; w < nexp; w++) begin
      push_exp(w, pack4(kept[4*w], kept[4*w+1], kept[4*w+2], kept[4*w+3]));
    end
    pulse_start();
    check("rnd_done_cleared", 32'(done), 32'd0);
    check("rnd_busy", 32'(busy), 32'd1);
    begin_frame();
    k = 0;
    for (int unsigned l = 0; l < nlines; l++) begin
      for (int unsigned i = 0; i < lens[l]; i++) begin
        href = 1'b1;
        din  = pix[k];
        k++;
        tick();
      end
      href = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        din = 6'($urandom);
        tick();
      end
    end
    end_frame();
    wait_done("rnd");
    check("rnd_word_cnt", 32'(word_cnt), nexp);
    check("rnd_overrun", 32'(overrun), 32'd0);
    check("rnd_busy_idle", 32'(busy), 32'd0);
    check("rnd_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // memory responder
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!ack_auto) begin
        mem_ack = 1'b0;
      end else if (!mem_we) begin
        mem_ack  = ($urandom_range(0, 3) == 0);
        ack_wait = $urandom_range(0, 2);
      end else if (ack_wait == 0) begin
        mem_ack = 1'b1;
      end else begin
        mem_ack = 1'b0;
        ack_wait--;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mem_we && mem_ack) begin
        n_accepts++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write actual addr=%0d data=0x%0h required=no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned lat;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; vsync = 1'b1; href = 1'b0; din = '0;
    tick(3);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    tick(4);

`ifndef CAM_CAPTURE_DECIM_EN
    // full frame, truncated at FW words; pixels 17..20 must be ignored
    for (int unsigned w = 0; w < 4; w++) begin
      push_exp(w, pack4(6'(4*w+1), 6'(4*w+2), 6'(4*w+3), 6'(4*w+4)));
    end
    pulse_start();
    check("full_busy", 32'(busy), 32'd1);
    begin_frame();
    drive_seq(1, 20);
    end_frame();
    wait_done("full");
    check("full_word_cnt", 32'(word_cnt), 32'd4);
    check("full_overrun", 32'(overrun), 32'd0);
    check("full_queue", exp_q.size(), 32'd0);

    // partial word discarded at end of frame
    push_exp(0, 32'h04030201);
    pulse_start();
    begin_frame();
    drive_seq(1, 6);
    end_frame();
    wait_done("part");
    check("part_word_cnt", 32'(word_cnt), 32'd1);
    check("part_queue", exp_q.size(), 32'd0);

    // ack stalled: first word held stable, later words dropped
    ack_auto = 1'b0;
    pulse_start();
    begin_frame();
    drive_seq(1, 12);
    a0 = mem_addr;
    d0 = mem_wdata;
    check("stall_we", 32'(mem_we), 32'd1);
    check("stall_addr0", 32'(a0), 32'd0);
    check("stall_data0", d0, 32'h04030201);
    tick(4);
    check("stall_addr_stable", 32'(mem_addr), 32'(a0));
    check("stall_data_stable", mem_wdata, d0);
    check("stall_overrun", 32'(overrun), 32'd1);
    push_exp(0, 32'h04030201);
    ack_auto = 1'b1;
    tick(6);
    check("stall_word_cnt", 32'(word_cnt), 32'd1);
    end_frame();
    wait_done("stall");
    check("stall_word_cnt_end", 32'(word_cnt), 32'd1);
    check("stall_overrun_end", 32'(overrun), 32'd1);
    check("stall_queue", exp_q.size(), 32'd0);

    // arming mid-frame skips that frame; start while busy is ignored
    vsync = 1'b0;
    tick(4);
    pulse_start();
    check("mid_overrun_cleared", 32'(overrun), 32'd0);
    base = n_accepts;
    drive_seq(1, 8);
    tick(3);
    check("mid_no_write", n_accepts - base, 32'd0);
    check("mid_we", 32'(mem_we), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    vsync = 1'b1;
    tick(4);
    pulse_start();
    check("mid_busy_armed", 32'(busy), 32'd1);
    push_exp(0, 32'h04030201);
    push_exp(1, 32'h08070605);
    begin_frame();
    drive_seq(1, 4);
    tick(8);
    check("mid_cnt1", 32'(word_cnt), 32'd1);
    pulse_start();
    check("mid_busy_cap", 32'(busy), 32'd1);
    drive_seq(5, 4);
    end_frame();
    wait_done("mid");
    check("mid_word_cnt", 32'(word_cnt), 32'd2);
    check("mid_queue", exp_q.size(), 32'd0);

    // issue latency, then abort with a write pending
    push_exp(0, 32'h04030201);
    pulse_start();
    begin_frame();
    drive_seq(1, 3);
    href = 1'b1;
    din  = 6'd4;
    lat  = 0;
    while (!mem_we && lat < 8) begin
      tick();
      lat++;
      if (lat == 1) begin
        href = 1'b0;
        din  = '0;
      end
    end
    check("we_latency", lat, 32'd3);
    lat = 0;
    while (word_cnt != 1 && lat < 20) begin
      tick();
      lat++;
    end
    check("abort_pre_cnt", 32'(word_cnt), 32'd1);
    ack_auto = 1'b0;
    drive_seq(5, 4);
    wait_we("abort");
    check("abort_pend_addr", 32'(mem_addr), 32'd1);
    check("abort_pend_data", mem_wdata, 32'h08070605);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_word_cnt", 32'(word_cnt), 32'd1);
    check("abort_overrun", 32'(overrun), 32'd0);
    base = n_accepts;
    ack_auto = 1'b1;
    tick(4);
    check("abort_no_write", n_accepts - base, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_wins", 32'(busy), 32'd0);
    vsync = 1'b1;
    tick(4);

    // asynchronous reset during a pending write
    ack_auto = 1'b0;
    pulse_start();
    begin_frame();
    drive_seq(1, 4);
    wait_we("arst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_data", mem_wdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_word_cnt", 32'(word_cnt), 32'd0);
    vsync = 1'b1;
    tick(2);
    rst = 1'b0;
    ack_auto = 1'b1;
    tick(3);
    check("arst_idle_busy", 32'(busy), 32'd0);
    check("arst_idle_we", 32'(mem_we), 32'd0);
`else
    // decimated line: only odd-valued (even-index) pixels are kept
    push_exp(0, 32'h07050301);
    pulse_start();
    begin_frame();
    drive_seq(1, 8);
    end_frame();
    wait_done("decim");
    check("decim_word_cnt", 32'(word_cnt), 32'd1);
    check("decim_queue", exp_q.size(), 32'd0);
`endif

    for (int unsigned f = 0; f < 16; f++) begin
      random_frame();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-capture sequencer between the camera pins (vsync, href, din) and an on-chip frame buffer written by word. It synchronises the camera signals and waits for a frame start. It then packs 6-bit pixels four per 32-bit word and writes them to memory through a request/acknowledge handshake. Software controls it through start/abort strobes and reads back busy/done/overrun and the word count, via an LM32 wishbone peripheral wrapper.

Parameters:
ADDR_W, 13, frame-buffer word-address width
FRAME_WORDS, 4800, max words stored per frame (160x120 px / 4); must be <= 2**ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle strobe: arm a capture (ignored while busy)
abort  in  1  one-cycle strobe: return to IDLE from any state
vsync  in  1  camera vertical sync, asynchronous; high = blanking
href  in  1  camera line-valid, asynchronous; high = pixel on din each clk
din  in  6  camera pixel data, asynchronous
mem_we  out  1  write request, held until mem_ack
mem_addr  out  ADDR_W  word address of pending write
mem_wdata  out  32  packed word of pending write
mem_ack  in  1  memory accepted the write this cycle
busy  out  1  state is ARMED, CAPTURE or DRAIN
done  out  1  sticky: frame complete; cleared by start/abort
overrun  out  1  sticky: word dropped (write still pending); cleared by start/abort
word_cnt  out  ADDR_W+1  words accepted by memory this frame

Behaviour:
- Reset (async, rst=1): state IDLE. mem_we, mem_addr, mem_wdata, busy, done, overrun, word_cnt all 0. Sync flops, pack register and lane counter are 0.
- Input sync: vsync, href and din each pass through two clk flops (vs_s, hr_s, d_s). Edges are detected on vs_s against its previous value.
- IDLE: start -> ARMED. Clear done, overrun, word_cnt, lane counter and address.
- ARMED: busy=1. On vs_s falling edge (1->0) -> CAPTURE. A frame already in progress at arm time is skipped.
- CAPTURE, per cycle with hr_s=1: d_s goes into byte lane k (bits 8k+5:8k, bits 8k+7:8k+6 = 0); lane 0 is filled first and k increments mod 4.
- When lane 3 fills, the word completes:
  - no write pending: next edge loads mem_wdata, sets mem_addr=word_cnt, raises mem_we.
  - write pending: the word is discarded, overrun<=1, the address does not advance.
- Handshake: mem_we, mem_addr and mem_wdata are stable while mem_we=1. On a cycle with mem_we=1 and mem_ack=1, mem_we drops at the next edge and word_cnt increments. mem_ack while mem_we=0 is ignored.
- Pipeline timing: mem_we rises on the 3rd clk edge after the 4th pixel is present at the pins (2 sync stages + 1 pack/issue stage). A new write can issue the cycle after an ack, giving a 1 word/4 clk sustained rate with zero-wait ack.
- CAPTURE exits to DRAIN when either of these occurs first:
  - vs_s rising edge (end of frame), or
  - word_cnt + pending word reaches FRAME_WORDS. Further pixels are ignored.
  - A partial word (lane != 0) is discarded at the transition.
- DRAIN: wait until no write is pending -> DONE.
- DONE: busy=0, done=1, word_cnt holds the final count. start -> ARMED (clears as in IDLE).
- abort in any state: next edge -> IDLE. mem_we<=0 and the pending write is dropped without being counted. done=0, overrun=0, word_cnt is kept.
- Simultaneous start and abort: abort wins.
- Simultaneous word completion and ack of the previous write: the new word issues, no overrun.
- Simultaneous end-of-frame and lane-3 completion: the completed word issues and is counted, then DRAIN.
- word_cnt saturates at FRAME_WORDS and never wraps. mem_addr never exceeds FRAME_WORDS-1.

Optional Feature:
CAM_CAPTURE_DECIM_EN
- Defined: 2:1 horizontal decimation. Only even pixels of each line are packed (a per-line phase bit resets when hr_s falls). Words per full line are halved.
- Undefined: every hr_s=1 pixel is packed. The phase bit and its logic are absent.

Test Plan:
1. rst=1 mid-CAPTURE with mem_we=1 -> all outputs 0 in the same cycle (before any clk edge); state IDLE after release.
2. FRAME_WORDS=4, mem_ack tied 1; start, vsync 1->0, href=1 for 16 clk with din=1..16 -> four writes to addr 0..3. Word0 = 0x04030201. done=1, word_cnt=4, overrun=0.
3. Same frame with 6 pixels then vsync 0->1 -> one write (0x04030201). The partial word is discarded, word_cnt=1, done=1.
4. mem_ack held 0 for 10 clk during continuous href -> first word stays pending with stable addr/data. The second word is dropped and overrun=1; after ack, word_cnt counts only accepted words.
5. start while vsync=0 mid-frame -> no write until the next vsync falling edge. A start pulse while busy=1 has no effect.
6. abort while mem_we=1 -> mem_we=0 next cycle, IDLE, busy=0, word_cnt unchanged. With CAM_CAPTURE_DECIM_EN and din=1..8 on one line -> a single word 0x07050301.
